pipe_arbiter: RTL and testbench
===============================

# pipe_arbiter

Round-robin scheduler that time-shares one `pipeline_buffer` serial bit path between four serial requesters (e.g., parallel branch-metric or traceback bit streams in the Viterbi decoder). Grants are issued in fixed-length frames. The arbiter drives the buffer's input and receives its output. It tags each returned bit with the owning requester ID and frame-boundary flags, aligned to the buffer latency.

## Interface
Parameters:
- `FRAME_LEN`, default 8: bits per grant; legal range 2..255.
- `PIPE_DEPTH`, default 1: latency in cycles of the attached pipeline buffer chain; legal range 1..8.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 4: per-requester frame request, level-sensitive.
- `ip_bits`, in, 4: per-requester serial data bit.
- `grant`, out, 4: one-hot grant, registered; all zero when idle.
- `pipe_ip`, out, 1: bit to pipeline buffer input; `ip_bits[granted]` when granted, else 0.
- `pipe_op`, in, 1: bit returned from pipeline buffer output.
- `out_bit`, out, 1: equal to `pipe_op`, qualified by `out_valid`.
- `out_valid`, out, 1: `out_bit` belongs to a granted frame.
- `out_id`, out, 2: requester index of `out_bit`.
- `out_sof`, out, 1: first bit of a frame.
- `out_eof`, out, 1: last bit of a frame.

## Operation
- FSM states: IDLE, XFER.
- IDLE behaviour:
  - `grant` = 0 and `pipe_ip` = 0.
  - If any `req` bit is set, choose a winner by round-robin, register the one-hot `grant`, clear the bit counter, and go to XFER.
- Round-robin rule:
  - Search starts at `last+1` mod 4, where `last` is the most recently granted index.
  - After reset, `last` = 3, so requester 0 has top priority.
- XFER behaviour:
  - `pipe_ip` = `ip_bits[sel]`, combinational from the registered `sel`.
  - The 8-bit counter `cnt` increments each cycle.
  - At `cnt == FRAME_LEN-1` the frame ends.
  - If any `req` is set at that cycle, the next winner is granted on the very next cycle, with no idle bubble. The just-served requester has the lowest priority.
  - Otherwise the FSM returns to IDLE.
- Frames are non-preemptive:
  - Deasserting `req[sel]` mid-frame does not shorten the frame.
  - The requester must keep supplying bits; whatever is on `ip_bits[sel]` is sent.
- A single continuous requester gets back-to-back frames only when no other `req` is set.
- Tag pipeline:
  - A PIPE_DEPTH-stage shift register carries {valid, id, sof, eof} for each cycle's `pipe_ip`.
  - Stage output drives `out_valid`, `out_id`, `out_sof`, `out_eof`, in step with `pipe_op`.
- Reset values: FSM=IDLE, `grant`=0, `pipe_ip`=0, `cnt`=0, `last`=3, all tag stages 0. Therefore `out_valid`, `out_id`, `out_sof`, `out_eof` = 0.
- Reset mid-frame:
  - The frame is abandoned and the tag pipeline is flushed.
  - `out_valid` = 0 from the cycle after the reset edge until new frames emerge.
  - Bits still inside the buffer are discarded, because the buffer shares `rst`.
- `req` asserted together with `rst`: `rst` wins. Arbitration occurs on the first edge after `rst` deasserts.

## Timing
- `req` sampled high in IDLE → `grant` high 1 cycle later. `pipe_ip` carries bit 0 in that same cycle.
- A frame occupies exactly FRAME_LEN consecutive cycles of `grant`.
- A bit driven on `pipe_ip` in cycle t appears on `out_bit` with its tag in cycle t+PIPE_DEPTH.
- `out_sof` and `out_eof` are each single-cycle pulses.
  - FRAME_LEN ≥ 2 guarantees they never coincide.
- Back-to-back frames: `out_eof` of frame k is followed by `out_sof` of frame k+1 in the next cycle.
- Worst-case wait for a requester held continuously high: 3 frames plus 1 cycle.

## Test plan
- Reset check: hold `rst`=1 for 2 cycles with `req`=4'b1111 → `grant`=0, `out_valid`=0. On the first edge after release, `grant`=4'b0001.
- Single frame: `req`=4'b0100 for 1 cycle, `ip_bits[2]` = 1,0,1,1,1,0,1,0 (FRAME_LEN=8, PIPE_DEPTH=1):
  - `grant`=4'b0100 for 8 cycles, then IDLE.
  - `out_bit` reproduces the sequence 1 cycle after `pipe_ip`.
  - `out_id`=2, with `out_sof` on the first bit and `out_eof` on the last.
- Round-robin: `req`=4'b1111 held high → grant order 0,1,2,3,0 with no idle cycle between frames. `out_id` follows the same order, delayed by PIPE_DEPTH.
- Fairness after service: requester 1 is granted, then `req`=4'b0011 at its last bit → next grant goes to 0, not 1.
- Mid-frame reset: assert `rst` at frame bit 4 → next cycle `grant`=0 and `out_valid`=0. No `out_eof` is ever emitted for that frame; after release, priority restarts at requester 0.
- Early request drop: `req[3]` deasserted after bit 2 → `grant[3]` still lasts 8 cycles and `out_eof` is still produced.

Source files
------------

// File: rtl/pipe_arbiter.sv
// pipe_arbiter: four serial requesters share one pipeline_buffer bit path.
// Each grant lasts FRAME_LEN cycles. A round-robin search starts after the
// most recently granted requester. Every bit sent into the buffer is tagged
// with {valid, id, sof, eof}. The tag travels through a PIPE_DEPTH-stage
// shift register, so it comes out in step with the bit returned on pipe_op.
module pipe_arbiter #(
  parameter int FRAME_LEN  = 8,
  parameter int PIPE_DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] ip_bits,
  output logic [3:0] grant,
  output logic       pipe_ip,
  input  logic       pipe_op,
  output logic       out_bit,
  output logic       out_valid,
  output logic [1:0] out_id,
  output logic       out_sof,
  output logic       out_eof
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  // Tag layout: [4] valid, [3:2] id, [1] sof, [0] eof
  localparam int TAG_W = 5;

  state_t           r_state, w_state_next;
  logic [3:0]       r_grant, w_grant_next;
  logic [1:0]       r_sel, w_sel_next;
  logic [1:0]       r_last, w_last_next;
  logic [7:0]       r_cnt, w_cnt_next;

  logic             w_any_req;
  logic             w_frame_end;
  logic             w_xfer;
  logic [1:0]       w_start;
  logic [7:0]       w_req2;
  logic [3:0]       w_rot;
  logic [1:0]       w_offset;
  logic [1:0]       w_winner;
  logic [TAG_W-1:0] w_tag_in;
  logic [TAG_W-1:0] r_tag [PIPE_DEPTH];

  assign w_any_req   = |req;
  assign w_xfer      = (r_state == XFER);
  assign w_frame_end = (r_cnt == 8'(FRAME_LEN - 1));

  // Rotate the request vector so the search starts just after the last
  // winner. The just-served requester then lands in the lowest-priority slot.
  assign w_start = r_last + 2'd1;
  assign w_req2  = {req, req};
  assign w_rot   = w_req2[w_start +: 4];

  // Priority-encode the rotated requests; the lowest offset wins.
  always_comb begin
    w_offset = 2'd3;
    if (w_rot[0])      w_offset = 2'd0;
    else if (w_rot[1]) w_offset = 2'd1;
    else if (w_rot[2]) w_offset = 2'd2;
  end

  assign w_winner = w_start + w_offset;

  // FSM state and frame bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_sel   <= w_sel_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic. Grant on a request from IDLE. At frame end, hand over
  // without a bubble if anyone is asking; otherwise fall back to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_sel_next   = r_sel;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_grant_next = 4'b0000;
        if (w_any_req) begin
          w_state_next = XFER;
          w_grant_next = 4'b0001 << w_winner;
          w_sel_next   = w_winner;
          w_last_next  = w_winner;
          w_cnt_next   = 8'd0;
        end
      end
      XFER: begin
        w_cnt_next = r_cnt + 8'd1;
        if (w_frame_end) begin
          w_cnt_next = 8'd0;
          if (w_any_req) begin
            w_grant_next = 4'b0001 << w_winner;
            w_sel_next   = w_winner;
            w_last_next  = w_winner;
          end else begin
            w_state_next = IDLE;
            w_grant_next = 4'b0000;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = 4'b0000;
      end
    endcase
  end

  assign grant   = r_grant;
  assign pipe_ip = w_xfer ? ip_bits[r_sel] : 1'b0;

  // Tag for the bit currently driven on pipe_ip
  assign w_tag_in = {w_xfer, r_sel, w_xfer & (r_cnt == 8'd0), w_xfer & w_frame_end};

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_tag
      // One tag stage. Reset flushes it, which discards any in-flight frame.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag[gi] <= '0;
        end else if (gi == 0) begin
          r_tag[gi] <= w_tag_in;
        end else begin
          r_tag[gi] <= r_tag[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign out_valid = r_tag[PIPE_DEPTH-1][4];
  assign out_id    = r_tag[PIPE_DEPTH-1][3:2];
  assign out_sof   = r_tag[PIPE_DEPTH-1][1];
  assign out_eof   = r_tag[PIPE_DEPTH-1][0];
  assign out_bit   = pipe_op & out_valid;

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed testbench for pipe_arbiter (FRAME_LEN=8, PIPE_DEPTH=1).
// The bench models a one-stage pipeline_buffer that shares rst with the DUT.
module tb_pipe_arbiter;
  localparam int FL = 8;
  localparam int PD = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ip_bits;
  logic [3:0] grant;
  logic       pipe_ip;
  logic       pipe_op;
  logic       out_bit;
  logic       out_valid;
  logic [1:0] out_id;
  logic       out_sof;
  logic       out_eof;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected tag of the previous cycle, which is what the outputs show now
  logic       p_valid = 1'b0;
  logic [1:0] p_id    = 2'd0;
  logic       p_sof   = 1'b0;
  logic       p_eof   = 1'b0;
  logic       p_bit   = 1'b0;

  pipe_arbiter #(.FRAME_LEN(FL), .PIPE_DEPTH(PD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ip_bits  (ip_bits),
    .grant    (grant),
    .pipe_ip  (pipe_ip),
    .pipe_op  (pipe_op),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_id   (out_id),
    .out_sof  (out_sof),
    .out_eof  (out_eof)
  );

  always #5 clk = ~clk;

  // Single-stage pipeline buffer, reset together with the arbiter
  always_ff @(posedge clk) begin
    if (rst) pipe_op <= 1'b0;
    else     pipe_op <= pipe_ip;
  end

  function automatic logic [1:0] idx(input logic [3:0] g);
    if (g[1])      return 2'd1;
    else if (g[2]) return 2'd2;
    else if (g[3]) return 2'd3;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge. Check this cycle's grant and pipe_ip, and the
  // tag expected from the previous cycle. Then record this cycle's tag.
  task automatic check_cycle(input string tag, input logic [3:0] e_grant,
                             input logic e_ip, input logic e_sof, input logic e_eof);
    @(negedge clk);
    chk({tag, " grant"},     grant,              e_grant);
    chk({tag, " pipe_ip"},   {3'b000, pipe_ip},  {3'b000, e_ip});
    chk({tag, " out_valid"}, {3'b000, out_valid}, {3'b000, p_valid});
    chk({tag, " out_sof"},   {3'b000, out_sof},  {3'b000, p_sof});
    chk({tag, " out_eof"},   {3'b000, out_eof},  {3'b000, p_eof});
    chk({tag, " out_bit"},   {3'b000, out_bit},  {3'b000, p_valid & p_bit});
    if (p_valid) chk({tag, " out_id"}, {2'b00, out_id}, {2'b00, p_id});
    p_valid = (e_grant != 4'b0000);
    p_id    = idx(e_grant);
    p_sof   = e_sof;
    p_eof   = e_eof;
    p_bit   = e_ip;
  endtask

  // Drive and check nbits cycles of a frame owned by requester id.
  // req is r_hold up to bit hold_until, req_last on the final bit, else 0.
  // ip_bits[id] carries pat[b]; the other lanes carry its complement.
  task automatic run_frame(input string tag, input int id, input logic [3:0] r_hold,
                           input int hold_until, input logic [3:0] req_last,
                           input logic [7:0] pat, input int nbits);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    for (int b = 0; b < nbits; b++) begin
      @(posedge clk); #1;
      if (b == FL - 1)        req = req_last;
      else if (b <= hold_until) req = r_hold;
      else                    req = 4'b0000;
      ip_bits = pat[b] ? oh : ~oh;
      check_cycle($sformatf("%s b%0d", tag, b), oh, pat[b], b == 0, b == FL - 1);
    end
    $display("frame %s: id=%0d bits=%0d pattern=%02h", tag, id, nbits, pat);
  endtask

  task automatic idle_cycle(input string tag, input logic [3:0] r);
    @(posedge clk); #1;
    req     = r;
    ip_bits = 4'hF;
    check_cycle(tag, 4'b0000, 1'b0, 1'b0, 1'b0);
    $display("idle %s: req=%b", tag, r);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    ip_bits = 4'b0000;

    // Reset held for two cycles with every requester asking
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // First edge after release grants requester 0
    run_frame("post_rst", 0, 4'b0000, -1, 4'b0000, 8'hA5, FL);
    idle_cycle("idle0", 4'b0000);
    idle_cycle("idle1", 4'b0100);

    // Single frame from requester 2: bits 1,0,1,1,1,0,1,0
    run_frame("single", 2, 4'b0000, -1, 4'b0000, 8'h5D, FL);
    idle_cycle("single_eof", 4'b0000);
    idle_cycle("idle3", 4'b1000);

    // Requester 3 granted, then reset arrives during bit 4
    run_frame("mid", 3, 4'b0000, -1, 4'b0000, 8'h3C, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    req     = 4'b1111;
    ip_bits = 4'b0000;
    p_valid = 1'b0;
    p_sof   = 1'b0;
    p_eof   = 1'b0;
    p_bit   = 1'b0;
    check_cycle("after_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    $display("reset during frame: grant cleared, tags flushed");

    // All four requesters held high: order 0,1,2,3,0 with no bubble
    run_frame("rr0", 0, 4'b1111, FL, 4'b1111, 8'h96, FL);
    run_frame("rr1", 1, 4'b1111, FL, 4'b1111, 8'hC3, FL);
    run_frame("rr2", 2, 4'b1111, FL, 4'b1111, 8'h0F, FL);
    run_frame("rr3", 3, 4'b1111, FL, 4'b1111, 8'hF0, FL);
    run_frame("rr4", 0, 4'b1111, FL, 4'b1111, 8'h69, FL);

    // Requester 1 served, both 0 and 1 asking at its last bit: 0 wins
    run_frame("fair1", 1, 4'b0010, FL, 4'b0011, 8'h81, FL);
    run_frame("fair0", 0, 4'b0000, -1, 4'b1000, 8'h7E, FL);

    // Requester 3 drops req after bit 2; frame still runs all 8 bits
    run_frame("drop", 3, 4'b1000, 2, 4'b0000, 8'hB4, FL);
    idle_cycle("drop_eof", 4'b0000);
    idle_cycle("end", 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
